// File: rtl/if_scratch_filler.sv
// -----------------------------------------------------------------------------
// if_scratch_filler
//
// Moves input-feature (IF) words from the IF input FIFO into the circular IF
// scratch-pad of a convolution PE. The write pointer is published so that the
// downstream pointer checker can compare it against its read pointers. The
// multiplier reads the scratch-pad through a combinational read port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse; loads total_words and begins a job
//   total_words       number of IF words in the job (0 allowed)
//   fifo_empty        IF FIFO empty flag
//   fifo_dout         FIFO data, valid the cycle after fifo_ren
//   fifo_ren          FIFO read strobe
//   write_start       oldest live scratch-pad slot, from the checker
//   scratch_write_en  checker permission to issue new writes
//   read_addr         read address (checker current_if), taken modulo depth
//   read_data         scratch-pad word at read_addr, zero latency
//   write_cnt_if      next slot to be written
//   write_addr_if     zero-extended copy of write_cnt_if
//   busy              high while a job is filling
//   done              one-cycle pulse when a job completes
// -----------------------------------------------------------------------------
module if_scratch_filler #(
  parameter int IF_CELL_SIZE    = 8,
  parameter int IF_ADDRESS_SIZE = 8,
  parameter int CELL_NUMS_IF    = 8,
  parameter int TOTAL_SIZE      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [TOTAL_SIZE-1:0]      total_words,
  input  logic                       fifo_empty,
  input  logic [IF_CELL_SIZE-1:0]    fifo_dout,
  output logic                       fifo_ren,
  input  logic [IF_ADDRESS_SIZE:0]   write_start,
  input  logic                       scratch_write_en,
  input  logic [IF_ADDRESS_SIZE:0]   read_addr,
  output logic [IF_CELL_SIZE-1:0]    read_data,
  output logic [IF_ADDRESS_SIZE-1:0] write_cnt_if,
  output logic [IF_ADDRESS_SIZE:0]   write_addr_if,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = (CELL_NUMS_IF > 1) ? $clog2(CELL_NUMS_IF) : 1;
  localparam logic [IF_ADDRESS_SIZE:0] DEPTH = (IF_ADDRESS_SIZE+1)'(CELL_NUMS_IF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [TOTAL_SIZE-1:0]      remaining_q, remaining_d;
  logic                       rd_pending_q, rd_pending_d;
  logic [IF_ADDRESS_SIZE-1:0] write_cnt_q, write_cnt_d;

  logic [IF_CELL_SIZE-1:0]    mem [CELL_NUMS_IF];

  logic [IF_ADDRESS_SIZE:0]   ahead_raw;
  logic [IF_ADDRESS_SIZE:0]   ahead;
  logic [IF_ADDRESS_SIZE:0]   inc_raw;
  logic [IF_ADDRESS_SIZE:0]   rd_idx;
  logic                       full_int;

  // Slot the next issued read would land in, counting a word already in
  // flight. write_cnt_q is always below the depth, so the sum never exceeds
  // depth+1 and a single conditional subtract is an exact modulo for any
  // depth, power of two or not.
  always_comb begin
    ahead_raw = {1'b0, write_cnt_q} + (IF_ADDRESS_SIZE+1)'(rd_pending_q)
              + (IF_ADDRESS_SIZE+1)'(1);
    ahead     = (ahead_raw >= DEPTH) ? (ahead_raw - DEPTH) : ahead_raw;
    full_int  = (ahead == write_start);
  end

  // Write pointer increment with explicit wrap at the depth.
  always_comb begin
    inc_raw = {1'b0, write_cnt_q} + (IF_ADDRESS_SIZE+1)'(1);
    if (inc_raw == DEPTH) begin
      inc_raw = '0;
    end
  end

  // Next-state, datapath and FIFO strobe.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    remaining_d  = remaining_q;
    rd_pending_d = 1'b0;
    write_cnt_d  = write_cnt_q;
    fifo_ren     = 1'b0;

    // A word requested last cycle lands now regardless of state or of the
    // checker permission; only new requests are gated.
    if (rd_pending_q) begin
      write_cnt_d = inc_raw[IF_ADDRESS_SIZE-1:0];
      remaining_d = remaining_q - TOTAL_SIZE'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = total_words;
          state_d     = (total_words == '0) ? S_DONE : S_FILL;
        end
      end

      S_FILL: begin
        // Requests stop once every outstanding word is covered by one
        // already in flight, so the FIFO is never over-read.
        fifo_ren     = !fifo_empty && scratch_write_en && !full_int
                    && (remaining_q > TOTAL_SIZE'(rd_pending_q));
        rd_pending_d = fifo_ren;
        if (rd_pending_q && (remaining_q == TOTAL_SIZE'(1))) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      rd_pending_q <= 1'b0;
      write_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before the edge, independent of statement order.
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      rd_pending_q <= rd_pending_d;
      write_cnt_q  <= write_cnt_d;
    end
  end

  // NOTE: the scratch-pad has no reset; contents are only meaningful once
  // written, and leaving it out of the reset tree lets it map to plain
  // storage. A reset clears rd_pending_q asynchronously, so an in-flight
  // word is dropped rather than written.
  always_ff @(posedge clk) begin
    if (rd_pending_q) begin
      mem[IDX_W'(write_cnt_q)] <= fifo_dout;
    end
  end

  // Combinational read; the checker address is reduced modulo the depth.
  always_comb begin
    rd_idx    = read_addr % DEPTH;
    read_data = mem[IDX_W'(rd_idx)];
  end

  assign write_cnt_if  = write_cnt_q;
  assign write_addr_if = {1'b0, write_cnt_q};
  assign busy          = (state_q == S_FILL);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_if_scratch_filler.sv
// -----------------------------------------------------------------------------
// tb_if_scratch_filler
//
// Self-checking bench for if_scratch_filler. A FIFO model hands out words on
// fifo_ren; every accepted word pushes its expected slot and data onto a
// scoreboard queue. Each time the write pointer moves, the oldest entry is
// popped and compared with the written slot (read back via read_addr).
// -----------------------------------------------------------------------------
module tb_if_scratch_filler;

  localparam int CW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int TW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [TW-1:0] total_words;
  logic          fifo_empty;
  logic [CW-1:0] fifo_dout;
  logic          fifo_ren;
  logic [AW:0]   write_start;
  logic          scratch_write_en;
  logic [AW:0]   read_addr;
  logic [CW-1:0] read_data;
  logic [AW-1:0] write_cnt_if;
  logic [AW:0]   write_addr_if;
  logic          busy;
  logic          done;

  if_scratch_filler #(
    .IF_CELL_SIZE   (CW),
    .IF_ADDRESS_SIZE(AW),
    .CELL_NUMS_IF   (DEPTH),
    .TOTAL_SIZE     (TW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .total_words     (total_words),
    .fifo_empty      (fifo_empty),
    .fifo_dout       (fifo_dout),
    .fifo_ren        (fifo_ren),
    .write_start     (write_start),
    .scratch_write_en(scratch_write_en),
    .read_addr       (read_addr),
    .read_data       (read_data),
    .write_cnt_if    (write_cnt_if),
    .write_addr_if   (write_addr_if),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] slot;
    logic [CW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] fifo_q[$];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc;
  int            done_cnt, done_cyc, ren_cnt, first_ren, last_ren, wr_cnt;
  logic          bubble_mode, bubble;
  logic [AW-1:0] exp_wp, prev_wcnt;
  logic [CW-1:0] slot2_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic update_empty();
    fifo_empty = (fifo_q.size() == 0) || (bubble_mode && bubble);
  endtask

  task automatic clear_stats();
    done_cnt  = 0;
    done_cyc  = -1;
    ren_cnt   = 0;
    first_ren = -1;
    last_ren  = -1;
    wr_cnt    = 0;
  endtask

  // One clock: sample control at the falling edge, then after the rising
  // edge serve the FIFO and score any write that just happened.
  task automatic tick();
    logic ren_s;
    exp_t e;
    @(negedge clk);
    cyc++;
    ren_s = fifo_ren;
    check("ren_while_empty", 32'(fifo_ren & fifo_empty), 32'd0);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ren_s) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc;
      last_ren = cyc;
    end
    @(posedge clk);
    #1;
    if (ren_s) begin
      if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
      sb.push_back('{slot: exp_wp, data: fifo_dout});
      exp_wp = (exp_wp == AW'(DEPTH - 1)) ? '0 : exp_wp + AW'(1);
    end
    if (write_cnt_if != prev_wcnt) begin
      wr_cnt++;
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        read_addr = {1'b0, prev_wcnt};
        #1;
        check("wr_slot", 32'(prev_wcnt), 32'(e.slot));
        check("wr_data", 32'(read_data), 32'(e.data));
      end
    end
    prev_wcnt = write_cnt_if;
    if (bubble_mode) bubble = ~bubble;
    update_empty();
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    total_words = TW'(n);
    tick();
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic release_reset();
    sb.delete();
    fifo_q.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_wcnt = write_cnt_if;
    exp_wp    = '0;
    update_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    start            = 1'b0;
    total_words      = '0;
    fifo_empty       = 1'b1;
    fifo_dout        = '0;
    write_start      = '0;
    read_addr        = '0;
    scratch_write_en = 1'b1;
    bubble_mode      = 1'b0;
    bubble           = 1'b0;
    exp_wp           = '0;
    cyc              = 0;
    clear_stats();

    // Reset state
    #12;
    check("rst_fifo_ren", 32'(fifo_ren), 32'd0);
    check("rst_wcnt", 32'(write_cnt_if), 32'd0);
    check("rst_waddr", 32'(write_addr_if), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    release_reset();

    // Basic fill: five words from slot 0
    for (int i = 0; i < 5; i++) fifo_q.push_back(CW'(8'hA0 + i));
    update_empty();
    clear_stats();
    do_start(5);
    run_until_done(20);
    check("t1_first_ren", 32'(first_ren), 32'd1);
    check("t1_last_ren", 32'(last_ren), 32'd5);
    check("t1_ren_cnt", 32'(ren_cnt), 32'd5);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd5);
    check("t1_done_cyc", 32'(done_cyc), 32'd7);
    check("t1_wcnt", 32'(write_cnt_if), 32'd5);
    check("t1_waddr", 32'(write_addr_if), 32'd5);
    check("t1_busy_after", 32'(busy), 32'd0);
    read_addr = 9'd3;
    #1;
    check("t1_read3", 32'(read_data), 32'hA3);
    read_addr = 9'd11;
    #1;
    check("t1_read11_mod", 32'(read_data), 32'hA3);

    // Zero length job
    clear_stats();
    do_start(0);
    run_until_done(5);
    check("t5_done_cyc", 32'(done_cyc), 32'd1);
    check("t5_ren_cnt", 32'(ren_cnt), 32'd0);
    check("t5_wcnt", 32'(write_cnt_if), 32'd5);

    // FIFO bubbles: empty every other cycle
    write_start = 9'd4;
    for (int i = 0; i < 3; i++) fifo_q.push_back(CW'(8'hB0 + i));
    bubble_mode = 1'b1;
    bubble      = 1'b1;
    update_empty();
    clear_stats();
    do_start(3);
    run_until_done(30);
    repeat (2) tick();
    bubble_mode = 1'b0;
    bubble      = 1'b0;
    update_empty();
    check("t4_wr_cnt", 32'(wr_cnt), 32'd3);
    check("t4_ren_cnt", 32'(ren_cnt), 32'd3);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    check("t4_wcnt", 32'(write_cnt_if), 32'd0);

    // Full stall from a fresh ring, resumed by the checker
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    release_reset();
    write_start = 9'd0;
    for (int i = 0; i < 10; i++) fifo_q.push_back(CW'($urandom_range(255)));
    update_empty();
    clear_stats();
    do_start(10);
    repeat (15) tick();
    check("t2_stall_wcnt", 32'(write_cnt_if), 32'd7);
    check("t2_stall_busy", 32'(busy), 32'd1);
    check("t2_stall_ren", 32'(fifo_ren), 32'd0);
    check("t2_stall_wr", 32'(wr_cnt), 32'd7);
    write_start = 9'd3;
    run_until_done(30);
    repeat (2) tick();
    check("t2_wr_cnt", 32'(wr_cnt), 32'd10);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_wcnt", 32'(write_cnt_if), 32'd2);

    // Wrap-around: move the pointer to 6, then fill 6,7,0,1
    write_start = 9'd1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(CW'(8'hC0 + i));
    slot2_val = 8'hC0;
    update_empty();
    clear_stats();
    do_start(4);
    run_until_done(20);
    check("t3_pre_wcnt", 32'(write_cnt_if), 32'd6);
    write_start = 9'd5;
    for (int i = 0; i < 4; i++) fifo_q.push_back(CW'(8'hD0 + i));
    update_empty();
    clear_stats();
    do_start(4);
    run_until_done(20);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd4);
    check("t3_wcnt", 32'(write_cnt_if), 32'd2);
    read_addr = 9'd0;
    #1;
    check("t3_read0", 32'(read_data), 32'hD2);

    // Reset mid-job with a word in flight
    for (int i = 0; i < 3; i++) fifo_q.push_back(CW'(8'hE0 + i));
    update_empty();
    clear_stats();
    do_start(3);
    tick();
    check("t6_pending_ren", 32'(ren_cnt), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ren", 32'(fifo_ren), 32'd0);
    check("t6_rst_wcnt", 32'(write_cnt_if), 32'd0);
    check("t6_rst_waddr", 32'(write_addr_if), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    check("t6_rst_done_hold", 32'(done), 32'd0);
    read_addr = 9'd2;
    #1;
    check("t6_no_write", 32'(read_data), 32'(slot2_val));
    release_reset();
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'hF1);
    update_empty();
    clear_stats();
    do_start(2);
    run_until_done(20);
    check("t6_after_wr", 32'(wr_cnt), 32'd2);
    check("t6_after_ren", 32'(ren_cnt), 32'd2);
    check("t6_after_wcnt", 32'(write_cnt_if), 32'd2);
    check("t6_sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_scratch_filler.md
Name: if_scratch_filler

Overview:
Upstream neighbour of the scratch-pad pointer checker in the convolution PE. It pulls input-feature (IF) words from the IF input FIFO and writes them into the circular IF scratch-pad. It publishes the write pointer (write_cnt_if / write_addr_if) that the checker compares against its read pointers. It also serves the combinational read port the multiplier uses at current_if.

Parameters:
IF_CELL_SIZE, 8, data width of one IF word
IF_ADDRESS_SIZE, 8, pointer width; extended address ports are IF_ADDRESS_SIZE+1 bits
CELL_NUMS_IF, 8, scratch-pad depth in words (any value ≥2, not necessarily a power of two)
TOTAL_SIZE, 16, width of the transfer-length counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; loads total_words and begins a fill job
total_words  input  TOTAL_SIZE  number of IF words in this job (0 allowed)
fifo_empty  input  1  IF FIFO empty
fifo_dout  input  IF_CELL_SIZE  FIFO data, valid the cycle after fifo_ren
fifo_ren  output  1  FIFO read strobe
write_start  input  IF_ADDRESS_SIZE+1  oldest live scratch-pad slot, driven by the checker
scratch_write_en  input  1  checker permission to write
read_addr  input  IF_ADDRESS_SIZE+1  read address (checker current_if)
read_data  output  IF_CELL_SIZE  scratch-pad word at read_addr
write_cnt_if  output  IF_ADDRESS_SIZE  next slot to be written
write_addr_if  output  IF_ADDRESS_SIZE+1  zero-extended copy of write_cnt_if
busy  output  1  job in progress
done  output  1  one-cycle pulse when the job completes

Behaviour:
- Reset (async, rst_n=0) clears the following:
  - outputs: fifo_ren=0, write_cnt_if=0, write_addr_if=0, busy=0, done=0.
  - internal state: remaining counter=0, rd_pending=0, FSM=IDLE.
  - storage: scratch-pad contents are not cleared. read_data reflects whatever the storage holds.
- Storage: CELL_NUMS_IF × IF_CELL_SIZE registers.
  - One synchronous write port.
  - read_data = mem[read_addr % CELL_NUMS_IF], combinational, 0-cycle latency.
- FSM states:
  - IDLE:
    - on start: remaining←total_words.
    - if total_words==0, go to DONE; otherwise go to FILL.
    - start is ignored in every state except IDLE.
  - FILL:
    - fifo_ren = !fifo_empty && scratch_write_en && !full_int && (remaining > rd_pending).
    - rd_pending ← fifo_ren (registered).
    - when remaining==1 and rd_pending==1 (last word landing), go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- busy=1 in FILL only.
- Write: in any cycle with rd_pending==1:
  - mem[write_cnt_if] ← fifo_dout.
  - write_cnt_if ← (write_cnt_if+1) % CELL_NUMS_IF (explicit wrap; no power-of-two assumption).
  - remaining ← remaining−1.
- full_int = ((write_cnt_if + rd_pending + 1) % CELL_NUMS_IF == write_start). This accounts for a word already in flight, so the buffer never overruns.
- At most CELL_NUMS_IF−1 words are ever live; one slot always stays empty.
- Throughput: 1 word per cycle when the FIFO is non-empty and there is space. First write lands 2 cycles after start (cycle 1: ren, cycle 2: write).
- Boundary and concurrency rules:
  - scratch_write_en deasserted mid-job stalls new reads only; a pending word still writes.
  - write_start advancing in the same cycle as a write is legal; full_int uses the current write_start.
  - write_cnt_if is not reset between jobs. It continues from its current value so the ring stays consistent with the checker.
  - rst_n asserted mid-job aborts immediately; a pending word is dropped and done is not pulsed.

Test Plan:
1. Basic fill: depth 8, write_start=0, total_words=5, FIFO holds A0..A4, never empty. Required response:
   - fifo_ren high cycles 1–5; writes at slots 0..4.
   - write_cnt_if=5; done pulses in cycle 7; read_addr=3 returns A3.
2. Full stall: write_start=0, total_words=10. Required response:
   - writes stop with write_cnt_if=7, busy=1, fifo_ren=0.
   - raising write_start to 3 resumes writing; slots 7,0,1 filled; done after word 10.
3. Wrap-around: write_cnt_if starts at 6, write_start=5, total_words=4. Required response: slots 6,7,0,1 written in order; final write_cnt_if=2.
4. FIFO bubbles: fifo_empty toggles every other cycle, total_words=3. Required response: fifo_ren only when non-empty; exactly 3 writes; done once.
5. Zero length: total_words=0. Required response: done one cycle after start; no fifo_ren; write_cnt_if unchanged.
6. Reset mid-job: rst_n low while rd_pending=1. Required response:
   - all outputs return to reset values asynchronously; no write occurs.
   - a later start works normally from write_cnt_if=0.
